// File: rtl/sd_port_sched.sv
// sd_port_sched: shares the hps_io SD sector channel between CD ISO reads and backup-RAM load/save, and formats backup RAM
// Ports:
//   clk_sys, reset_n                      clock, asynchronous active-low reset
//   cd_lba, cd_rd, cd_ack                 CD sector requester
//   bk_ena, bk_load, bk_save, format      backup image mounted writable, status-bit requests (rising edge)
//   dl_done, img_nz                       ROM download end pulse and non-empty image, triggers autoload
//   sd_lba, sd_rd, sd_wr, sd_ack          hps_io sector channel
//   sd_buff_addr, sd_buff_wr              hps_io sector buffer word index and write strobe
//   bram_addr_b, bram_data_b, bram_wr_b   backup RAM port B
//   bk_busy, bk_loading                   backup activity status
module sd_port_sched #(
    parameter int BK_SECTORS = 16,
    parameter int BK_LBA_W   = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [31:0]           cd_lba,
    input  logic                  cd_rd,
    output logic                  cd_ack,
    input  logic                  bk_ena,
    input  logic                  bk_load,
    input  logic                  bk_save,
    input  logic                  format,
    input  logic                  dl_done,
    input  logic                  img_nz,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic [7:0]            sd_buff_addr,
    input  logic                  sd_buff_wr,
    output logic [BK_LBA_W+7:0]   bram_addr_b,
    output logic [15:0]           bram_data_b,
    output logic                  bram_wr_b,
    output logic                  bk_busy,
    output logic                  bk_loading
);
    typedef enum logic [2:0] {IDLE, CD_REQ, CD_WAIT, BK_REQ, BK_WAIT, FMT} state_t;
    state_t state, state_nx;
    logic load_q, save_q, fmt_q, bk_pend, pend_load, fmt_pend, rr_bk;
    logic load_req, save_req, grant_bk, last_sec;
    logic [BK_LBA_W-1:0] bk_lba;
    logic [1:0] fmt_cnt;
    // autoload after a ROM download is treated exactly like a load request
    assign load_req = (bk_load & ~load_q) | (dl_done & img_nz);
    assign save_req = bk_save & ~save_q;
    // round-robin only matters when both requesters are waiting
    assign grant_bk = bk_pend & (rr_bk | ~cd_rd);
    assign last_sec = bk_lba == BK_LBA_W'(BK_SECTORS - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!sd_ack) state_nx = grant_bk ? BK_REQ : cd_rd ? CD_REQ : (fmt_pend && !bk_busy) ? FMT : IDLE;
            CD_REQ:  if (sd_ack) state_nx = CD_WAIT;
            CD_WAIT: if (!sd_ack) state_nx = IDLE;
            BK_REQ:  if (sd_ack) state_nx = BK_WAIT;
            BK_WAIT: if (!sd_ack) state_nx = IDLE;
            FMT:     if (&fmt_cnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign sd_rd = state == CD_REQ || (state == BK_REQ && bk_loading);
    assign sd_wr = state == BK_REQ && !bk_loading;
    assign cd_ack = sd_ack && (state == CD_REQ || state == CD_WAIT);
    assign bram_wr_b = state == FMT || (sd_buff_wr && sd_ack && bk_loading && (state == BK_REQ || state == BK_WAIT));
    assign bram_addr_b = state == FMT ? {{(BK_LBA_W+6){1'b0}}, fmt_cnt} : {bk_lba, sd_buff_addr};
    // HUBM header: "HU" "BM" then the two size/marker words
    assign bram_data_b = state != FMT ? 16'h0000 : fmt_cnt == 2'd0 ? 16'h5548 : fmt_cnt == 2'd1 ? 16'h4D42 : fmt_cnt == 2'd2 ? 16'h8800 : 16'h8010;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_q     <= 1'b0;
            save_q     <= 1'b0;
            fmt_q      <= 1'b0;
            bk_pend    <= 1'b0;
            pend_load  <= 1'b0;
            fmt_pend   <= 1'b0;
            rr_bk      <= 1'b0;
            bk_lba     <= '0;
            fmt_cnt    <= 2'd0;
            sd_lba     <= 32'd0;
            bk_busy    <= 1'b0;
            bk_loading <= 1'b0;
        end else begin
            load_q <= bk_load;
            save_q <= bk_save;
            fmt_q  <= format;
            if (bk_ena && !bk_busy && (load_req || save_req)) begin
                bk_pend   <= 1'b1;
                pend_load <= load_req;
            end
            if (state == IDLE && state_nx == CD_REQ) sd_lba <= cd_lba;
            if (state == IDLE && state_nx == BK_REQ) begin
                sd_lba     <= {{(32-BK_LBA_W){1'b0}}, bk_lba};
                bk_busy    <= 1'b1;
                bk_loading <= pend_load;
            end
            if (state == IDLE && state_nx == FMT) bk_busy <= 1'b1;
            if (state == CD_WAIT && !sd_ack) rr_bk <= 1'b1;
            // bk_lba wraps to 0 after the last sector, ready for the next transfer
            if (state == BK_WAIT && !sd_ack) begin
                rr_bk  <= 1'b0;
                bk_lba <= bk_lba + 1'b1;
                if (last_sec) begin
                    bk_busy    <= 1'b0;
                    bk_loading <= 1'b0;
                    bk_pend    <= 1'b0;
                end
            end
            if (state == FMT) begin
                fmt_cnt <= fmt_cnt + 2'd1;
                if (&fmt_cnt) begin
                    fmt_pend <= 1'b0;
                    bk_busy  <= 1'b0;
                end
            end
            // a new format edge wins over the end-of-format clear
            if (format && !fmt_q) fmt_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sd_port_sched.sv
// tb_sd_port_sched: directed bench for sd_port_sched with an hps_io responder
module tb_sd_port_sched;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cd_lba = 32'd0;
    logic        cd_rd = 1'b0;
    logic        cd_ack;
    logic        bk_ena = 1'b0, bk_load = 1'b0, bk_save = 1'b0, format = 1'b0, dl_done = 1'b0, img_nz = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic        sd_buff_wr = 1'b0;
    logic [11:0] bram_addr_b;
    logic [15:0] bram_data_b;
    logic        bram_wr_b, bk_busy, bk_loading;
    int n_chk = 0, n_pass = 0, wr_cnt = 0, addr_err = 0;
    logic [31:0] cur_lba = 32'd0;

    sd_port_sched dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cd_lba(cd_lba), .cd_rd(cd_rd), .cd_ack(cd_ack),
        .bk_ena(bk_ena), .bk_load(bk_load), .bk_save(bk_save), .format(format), .dl_done(dl_done),
        .img_nz(img_nz), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr), .bram_addr_b(bram_addr_b),
        .bram_data_b(bram_data_b), .bram_wr_b(bram_wr_b), .bk_busy(bk_busy), .bk_loading(bk_loading)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (bram_wr_b) begin
            wr_cnt++;
            if (sd_buff_wr && bram_addr_b != {cur_lba[3:0], sd_buff_addr}) addr_err++;
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one sector on the HPS side: wait for a request, check it, ack, optional buffer writes, release
    task automatic serve(input bit is_cd, input logic [31:0] lba, input bit is_load);
        int t = 0;
        while (!(sd_rd || sd_wr) && t < 100) begin
            tick;
            t++;
        end
        chk("req_seen", 32'(t < 100), 32'd1);
        chk("req_lba", sd_lba, lba);
        chk("req_dir", {sd_rd, sd_wr}, (is_cd || is_load) ? 2'b10 : 2'b01);
        cur_lba = lba;
        repeat (3) tick;
        sd_ack = 1'b1;
        tick;
        chk("req_drop", {sd_rd, sd_wr}, 2'b00);
        chk("cd_ack", cd_ack, is_cd);
        if (is_load)
            for (int i = 0; i < 256; i++) begin
                sd_buff_addr = 8'(i);
                sd_buff_wr = 1'b1;
                tick;
            end
        sd_buff_wr = 1'b0;
        sd_buff_addr = 8'd0;
        repeat (2) tick;
        sd_ack = 1'b0;
        tick;
    endtask

    initial begin
        logic [15:0] fmt_tbl [4];
        int base, t;
        bit seen;
        fmt_tbl = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
        #1;
        chk("rst_outs", {sd_rd, sd_wr, cd_ack, bram_wr_b, bk_busy, bk_loading}, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_bram", {bram_addr_b, bram_data_b}, 0);
        repeat (2) tick;
        reset_n = 1'b1;
        tick;

        // CD read: ack after 10 clocks, held 300
        cd_lba = 32'h1234;
        cd_rd = 1'b1;
        tick;
        chk("cd_rd_grant", {sd_rd, cd_ack}, 2'b10);
        chk("cd_lba", sd_lba, 32'h1234);
        repeat (9) tick;
        sd_ack = 1'b1;
        #1;
        chk("cd_ack_rise", cd_ack, 1);
        tick;
        chk("cd_rd_drop", {sd_rd, cd_ack}, 2'b01);
        cd_rd = 1'b0;
        repeat (299) tick;
        chk("cd_ack_hold", cd_ack, 1);
        sd_ack = 1'b0;
        #1;
        chk("cd_ack_fall", cd_ack, 0);
        tick;
        chk("cd_idle", {sd_rd, sd_wr, bk_busy}, 0);

        // full backup load
        bk_ena = 1'b1;
        bk_load = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serve(1'b0, i, 1'b1);
            chk("load_flags", {bk_busy, bk_loading}, i < 15 ? 2'b11 : 2'b00);
        end
        chk("load_wr_cnt", wr_cnt, 4096);
        chk("load_addr_err", addr_err, 0);

        // save interleaved with a continuous CD stream, format requested midway
        base = wr_cnt;
        cd_lba = 32'h00AB_CDEF;
        cd_rd = 1'b1;
        bk_save = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serve(1'b1, 32'h00AB_CDEF, 1'b0);
            serve(1'b0, i, 1'b0);
            chk("save_flags", {bk_busy, bk_loading}, i < 15 ? 2'b10 : 2'b00);
            if (i == 5) format = 1'b1;
        end
        cd_rd = 1'b0;
        chk("save_no_bram_wr", wr_cnt - base, 0);
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("fmt_wr_busy", {bram_wr_b, bk_busy, sd_rd, sd_wr}, 4'b1100);
            chk("fmt_addr", bram_addr_b, k);
            chk("fmt_data", bram_data_b, fmt_tbl[k]);
            tick;
        end
        chk("fmt_done", {bram_wr_b, bk_busy}, 2'b00);

        // requests that must be dropped
        bk_save = 1'b0;
        bk_load = 1'b0;
        bk_ena = 1'b0;
        tick;
        bk_save = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick;
            seen |= sd_wr | sd_rd | bk_busy;
        end
        chk("save_disabled", seen, 0);
        bk_ena = 1'b1;
        img_nz = 1'b0;
        dl_done = 1'b1;
        tick;
        dl_done = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick;
            seen |= sd_wr | sd_rd | bk_busy | bk_loading;
        end
        chk("autoload_empty", seen, 0);

        // reset in the middle of a load with the ack still held
        bk_load = 1'b1;
        serve(1'b0, 0, 1'b1);
        serve(1'b0, 1, 1'b1);
        t = 0;
        while (!sd_rd && t < 100) begin
            tick;
            t++;
        end
        chk("rst_req_seen", sd_lba, 2);
        sd_ack = 1'b1;
        repeat (3) tick;
        sd_buff_wr = 1'b1;
        #1;
        reset_n = 1'b0;
        bk_load = 1'b0;
        #1;
        chk("mid_rst_outs", {sd_rd, sd_wr, cd_ack, bram_wr_b, bk_busy, bk_loading}, 0);
        chk("mid_rst_lba", sd_lba, 0);
        sd_buff_wr = 1'b0;
        tick;
        reset_n = 1'b1;
        cd_lba = 32'h0000_ABCD;
        cd_rd = 1'b1;
        repeat (5) tick;
        chk("ack_held_no_grant", {sd_rd, cd_ack}, 2'b00);
        sd_ack = 1'b0;
        tick;
        chk("grant_after_ack", {sd_rd, bk_busy, bk_loading}, 3'b100);
        chk("grant_lba", sd_lba, 32'h0000_ABCD);
        sd_ack = 1'b1;
        tick;
        cd_rd = 1'b0;
        sd_ack = 1'b0;
        repeat (2) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
